mdr_bin2bcd_seq: RTL



---
 rtl/mdr_bin2bcd_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mdr_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: signed/unsigned magnitude to N_DIGITS BCD
// digits plus sign, using one double-dabble (shift-add-3) iteration per clock.
module mdr_bin2bcd_seq #(
    parameter int W_DATA   = 16,
    parameter int W_BCD    = 4,
    parameter int N_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      signed_i,
    input  logic [W_DATA-1:0]         data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      sign_o,
    output logic [N_DIGITS*W_BCD-1:0] bcd_o
);

    localparam int W_ACC = N_DIGITS * W_BCD;
    localparam int CNT_W = $clog2(W_DATA);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_DATA-1:0]  shreg_q, shreg_d;
    logic [W_ACC-1:0]   acc_q, acc_d;
    logic [W_ACC-1:0]   adj_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sign_q, sign_d;
    logic [W_ACC-1:0]   bcd_q, bcd_d;

    // Digit correction so that the following left shift carries correctly into the next decade.
    function automatic logic [W_BCD-1:0] add3(input logic [W_BCD-1:0] d);
        logic [W_BCD-1:0] r;
        if (d >= W_BCD'(5)) begin
            r = d + W_BCD'(3);
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Next-state, datapath and output-register inputs.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        adj_s   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            adj_s[i*W_BCD +: W_BCD] = add3(acc_q[i*W_BCD +: W_BCD]);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Two's-complement negate of the most negative value yields its own
                    // bit pattern, which read unsigned is the correct magnitude.
                    if (signed_i && data_i[W_DATA-1]) begin
                        shreg_d = ~data_i + W_DATA'(1);
                    end else begin
                        shreg_d = data_i;
                    end
                    neg_d   = signed_i & data_i[W_DATA-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                {acc_d, shreg_d} = {adj_s, shreg_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                sign_d  = neg_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sign_o = sign_q;
    assign bcd_o  = bcd_q;

endmodule
